// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the MIPS I/D requesters, the memory arbiter and the
// word memory's read/write ports.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] m_raddr;
    logic [31:0] m_rdata;
    logic        m_write;
    logic [31:0] m_waddr;
    logic [31:0] m_wdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_gnt, i_valid, i_rdata, i_err,
        output d_gnt, d_valid, d_rdata, d_err,
        output m_raddr, m_write, m_waddr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_valid, i_rdata, i_err,
        input  d_gnt, d_valid, d_rdata, d_err,
        input  m_raddr, m_write, m_waddr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the shared memory read port between I fetches and D reads (D first,
// with a starvation escape for I), forwards D writes, and returns responses one cycle later.
module mem_arbiter #(
    parameter int MEMSIZE      = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam logic [31:0] MAX_ADDR = 32'(MEMSIZE - 4);
    localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);

    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr <= MAX_ADDR);
    endfunction

    logic        i_legal_s;
    logic        d_legal_s;
    logic        d_rd_s;
    logic        d_wr_s;
    logic        starved_s;
    logic        i_gnt_s;
    logic        d_gnt_s;
    logic [31:0] m_raddr_s;
    logic        m_write_s;
    logic [3:0]  starve_nxt_s;
    logic [3:0]  starve_cnt_r;
    logic        i_valid_r;
    logic        i_err_r;
    logic [31:0] i_rdata_r;
    logic        d_valid_r;
    logic        d_err_r;
    logic [31:0] d_rdata_r;

    // Arbitration, read-port address steering and write-port enable
    always_comb begin
        i_legal_s = addr_legal(bus.i_addr);
        d_legal_s = addr_legal(bus.d_addr);
        d_rd_s    = bus.d_req & ~bus.d_we;
        d_wr_s    = bus.d_req & bus.d_we;
        starved_s = (starve_cnt_r == LIMIT);
        // Writes never touch the read port, so only a D read can block I
        i_gnt_s   = bus.i_req & (~d_rd_s | starved_s);
        d_gnt_s   = d_wr_s | (d_rd_s & ~(bus.i_req & starved_s));
        m_write_s = rst_n & d_gnt_s & d_wr_s & d_legal_s;
        m_raddr_s = 32'h0000_0000;
        if (i_gnt_s && i_legal_s) begin
            m_raddr_s = bus.i_addr;
        end else if (d_gnt_s && d_rd_s && d_legal_s) begin
            m_raddr_s = bus.d_addr;
        end else begin
            m_raddr_s = 32'h0000_0000;
        end
    end

    // Next value of the run of consecutive denied I cycles, saturating at the limit
    always_comb begin
        starve_nxt_s = 4'd0;
        if (bus.i_req && !i_gnt_s) begin
            if (starved_s) begin
                starve_nxt_s = starve_cnt_r;
            end else begin
                starve_nxt_s = starve_cnt_r + 4'd1;
            end
        end else begin
            starve_nxt_s = 4'd0;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= 4'd0;
        end else begin
            starve_cnt_r <= starve_nxt_s;
        end
    end

    // I response register; data/err hold when nothing was granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_valid_r <= 1'b0;
            i_err_r   <= 1'b0;
            i_rdata_r <= 32'h0000_0000;
        end else begin
            i_valid_r <= i_gnt_s;
            if (i_gnt_s) begin
                i_err_r   <= ~i_legal_s;
                i_rdata_r <= i_legal_s ? bus.m_rdata : 32'h0000_0000;
            end
        end
    end

    // D response register; writes and errors return zero data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid_r <= 1'b0;
            d_err_r   <= 1'b0;
            d_rdata_r <= 32'h0000_0000;
        end else begin
            d_valid_r <= d_gnt_s;
            if (d_gnt_s) begin
                d_err_r   <= ~d_legal_s;
                d_rdata_r <= (d_rd_s && d_legal_s) ? bus.m_rdata : 32'h0000_0000;
            end
        end
    end

    assign bus.i_gnt   = i_gnt_s;
    assign bus.d_gnt   = d_gnt_s;
    assign bus.m_raddr = m_raddr_s;
    assign bus.m_write = m_write_s;
    assign bus.m_waddr = bus.d_addr;
    assign bus.m_wdata = bus.d_wdata;
    assign bus.i_valid = i_valid_r;
    assign bus.i_err   = i_err_r;
    assign bus.i_rdata = i_rdata_r;
    assign bus.d_valid = d_valid_r;
    assign bus.d_err   = d_err_r;
    assign bus.d_rdata = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked against a
// transaction-level model of the arbitration rules and a shadow copy of memory.
module tb_mem_arbiter;

    localparam int MEMSIZE      = 1024;
    localparam int STARVE_LIMIT = 4;
    localparam int WORDS        = MEMSIZE / 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_arbiter_if bus ();

    mem_arbiter #(.MEMSIZE(MEMSIZE), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // attached memory: combinational read, write on the rising edge
    logic [31:0] mem [WORDS];
    always_comb bus.m_rdata = mem[bus.m_raddr[9:2]];
    always @(posedge clk) begin
        if (bus.m_write) mem[bus.m_waddr[9:2]] <= bus.m_wdata;
    end

    // reference model state
    logic [31:0] ref_mem [WORDS];
    int          denied_run;
    logic        exp_i_valid, exp_i_err, exp_d_valid, exp_d_err;
    logic [31:0] exp_i_rdata, exp_d_rdata;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit legal_addr(input logic [31:0] a);
        return (a % 32'd4 == 32'd0) && (a <= 32'(MEMSIZE - 4));
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'(($urandom_range(0, 63) * 4) + $urandom_range(1, 3));
        if (r == 1) return 32'(MEMSIZE + $urandom_range(0, 15) * 4);
        if (r == 2) return 32'(MEMSIZE - 4);
        return 32'($urandom_range(0, 15) * 4);
    endfunction

    task automatic model_reset();
        denied_run  = 0;
        exp_i_valid = 1'b0; exp_i_err = 1'b0; exp_i_rdata = 32'h0;
        exp_d_valid = 1'b0; exp_d_err = 1'b0; exp_d_rdata = 32'h0;
    endtask

    task automatic check_resp(input string tag);
        check_val({tag, ".i_valid"}, 32'(bus.i_valid), 32'(exp_i_valid));
        check_val({tag, ".i_err"},   32'(bus.i_err),   32'(exp_i_err));
        check_val({tag, ".i_rdata"}, bus.i_rdata,      exp_i_rdata);
        check_val({tag, ".d_valid"}, 32'(bus.d_valid), 32'(exp_d_valid));
        check_val({tag, ".d_err"},   32'(bus.d_err),   32'(exp_d_err));
        check_val({tag, ".d_rdata"}, bus.d_rdata,      exp_d_rdata);
    endtask

    // One clock cycle: inputs were set at the falling edge; check grants, clock, check responses
    task automatic cycle(input string tag, output bit ig, output bit dg);
        bit          d_rd, d_wr, i_ok, d_ok;
        logic [31:0] exp_raddr, i_data, d_data;
        #1;
        d_rd = bus.d_req && !bus.d_we;
        d_wr = bus.d_req && bus.d_we;
        i_ok = legal_addr(bus.i_addr);
        d_ok = legal_addr(bus.d_addr);
        if (bus.i_req && d_rd) begin
            ig = (denied_run >= STARVE_LIMIT);
            dg = !ig;
        end else begin
            ig = bus.i_req;
            dg = bus.d_req;
        end
        exp_raddr = 32'h0;
        if (ig && i_ok) exp_raddr = bus.i_addr;
        if (dg && d_rd && d_ok) exp_raddr = bus.d_addr;
        check_val({tag, ".i_gnt"},   32'(bus.i_gnt),   32'(ig));
        check_val({tag, ".d_gnt"},   32'(bus.d_gnt),   32'(dg));
        check_val({tag, ".m_raddr"}, bus.m_raddr,      exp_raddr);
        check_val({tag, ".m_write"}, 32'(bus.m_write), 32'(dg && d_wr && d_ok));
        if (dg && d_wr && d_ok) begin
            check_val({tag, ".m_waddr"}, bus.m_waddr, bus.d_addr);
            check_val({tag, ".m_wdata"}, bus.m_wdata, bus.d_wdata);
        end
        i_data = i_ok ? ref_mem[int'(bus.i_addr / 32'd4)] : 32'h0;
        d_data = (d_rd && d_ok) ? ref_mem[int'(bus.d_addr / 32'd4)] : 32'h0;
        @(posedge clk);
        exp_i_valid = ig;
        if (ig) begin
            exp_i_err   = !i_ok;
            exp_i_rdata = i_data;
        end
        exp_d_valid = dg;
        if (dg) begin
            exp_d_err   = !d_ok;
            exp_d_rdata = d_data;
        end
        if (dg && d_wr && d_ok) ref_mem[int'(bus.d_addr / 32'd4)] = bus.d_wdata;
        if (bus.i_req && !ig) denied_run = (denied_run < STARVE_LIMIT) ? denied_run + 1 : STARVE_LIMIT;
        else                  denied_run = 0;
        #1;
        check_resp(tag);
        @(negedge clk);
    endtask

    initial begin
        bit ig, dg;
        int first_i;
        checks = 0;
        errors = 0;
        for (int k = 0; k < WORDS; k++) begin
            mem[k]     = 32'($urandom);
            ref_mem[k] = mem[k];
        end
        mem[2]     = 32'h1122_3344;
        ref_mem[2] = 32'h1122_3344;

        // reset with both requesters active, D presenting a legal write
        rst_n       = 1'b0;
        bus.i_req   = 1'b1; bus.i_addr = 32'h8;
        bus.d_req   = 1'b1; bus.d_we   = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'hCAFE_F00D;
        model_reset();
        #1;
        check_val("rst.m_write", 32'(bus.m_write), 32'h0);
        check_resp("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.d_we = 1'b0;
        rst_n    = 1'b1;
        cycle("first_d", ig, dg);
        bus.d_req = 1'b0;
        cycle("i_alone", ig, dg);
        check_val("i_alone.data", exp_i_rdata, 32'h1122_3344);
        bus.i_req = 1'b0;
        cycle("idle", ig, dg);

        // write and read of the same word in one cycle: reader sees old data
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEAD_BEEF;
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        cycle("rdw", ig, dg);
        bus.d_req = 1'b0;
        cycle("rdw_after", ig, dg);
        check_val("rdw_after.data", bus.i_rdata, 32'hDEAD_BEEF);
        bus.i_req = 1'b0;
        cycle("idle2", ig, dg);

        // continuous D reads with I held: I must win once every STARVE_LIMIT+1 cycles
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
        bus.i_req = 1'b1; bus.i_addr = 32'h24;
        first_i = -1;
        for (int c = 0; c < 3 * (STARVE_LIMIT + 1); c++) begin
            cycle("starve", ig, dg);
            if (ig && first_i < 0) first_i = c;
        end
        check_val("starve.first_i", 32'(first_i), 32'(STARVE_LIMIT));
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        cycle("idle3", ig, dg);

        // illegal accesses: misaligned D read and out-of-range I read, then illegal write
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h6;
        bus.i_req = 1'b1; bus.i_addr = 32'(MEMSIZE);
        cycle("bad_d", ig, dg);
        bus.d_req = 1'b0;
        cycle("bad_i", ig, dg);
        bus.i_req = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_1002;
        cycle("bad_wr", ig, dg);
        bus.d_req = 1'b0;
        cycle("idle4", ig, dg);

        // random traffic honouring the hold-until-granted rule
        for (int c = 0; c < 600; c++) begin
            cycle("rand", ig, dg);
            if (!bus.i_req || ig) begin
                bus.i_req  = ($urandom_range(0, 3) != 0);
                bus.i_addr = rand_addr();
            end else if ($urandom_range(0, 9) == 0) begin
                bus.i_req = 1'b0;
            end
            if (!bus.d_req || dg) begin
                bus.d_req   = ($urandom_range(0, 3) != 0);
                bus.d_we    = ($urandom_range(0, 2) == 0);
                bus.d_addr  = rand_addr();
                bus.d_wdata = 32'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                bus.d_req = 1'b0;
            end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        cycle("idle5", ig, dg);

        // reset mid-operation with partial starvation built up
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8;
        bus.i_req = 1'b1; bus.i_addr = 32'hC;
        repeat (3) cycle("pre_rst", ig, dg);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_resp("mid_rst");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_resp("in_rst");
        end
        @(negedge clk);
        rst_n   = 1'b1;
        first_i = -1;
        for (int c = 0; c < STARVE_LIMIT + 2; c++) begin
            cycle("post_rst", ig, dg);
            if (ig && first_i < 0) first_i = c;
        end
        check_val("post_rst.first_i", 32'(first_i), 32'(STARVE_LIMIT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
